// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, serial data width and the
// default baud divider used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned BAUD_DIVIDER_DEFAULT = 434;
    localparam int unsigned DATA_W               = 8;

    typedef logic [DATA_W-1:0] uart_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Serial line plus received-byte side-band of the UART receiver.
interface uart_receiver_if;
    import uart_pkg::*;

    logic       rx;
    uart_byte_t data_out;
    logic       data_valid;
    logic       framing_error;
    logic       busy;

    // master: the receiver; slave: the consumer that also drives the line
    modport master (input rx, output data_out, data_valid, framing_error, busy);
    modport slave  (output rx, input data_out, data_valid, framing_error, busy);

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line plus a registered
// falling-edge flag that is high in the first cycle rx_s reads low after high.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic rx_meta;

    // rx_s holds the previous sample when fall is computed, so fall lines up
    // with the first low rx_s exactly like a prev_rx_s/rx_s compare would.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            fall    <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            fall    <= rx_s & ~rx_meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: start-bit verification at half period, LSB-first data
// sampling at mid-bit, stop-bit check with one-cycle valid / framing-error pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIVIDER = BAUD_DIVIDER_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_receiver_if.master bus
);

    localparam int unsigned HALF_BIT = (BAUD_DIVIDER + 1) / 2;
    localparam int unsigned CNT_W    = $clog2(BAUD_DIVIDER + 1) + 1;
    localparam int unsigned IDX_W    = 3;

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BAUD_DIVIDER);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    rx_state_e        state,    state_nxt;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
    logic [IDX_W-1:0] bit_idx,  bit_idx_nxt;
    uart_byte_t       shift_q,  shift_nxt;
    uart_byte_t       data_q,   data_nxt;
    logic             valid_q,  valid_nxt;
    logic             ferr_q,   ferr_nxt;
    logic             busy_q;

    logic rx_s;
    logic fall;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (bus.rx),
        .rx_s  (rx_s),
        .fall  (fall)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            shift_q  <= shift_nxt;
            data_q   <= data_nxt;
            valid_q  <= valid_nxt;
            ferr_q   <= ferr_nxt;
            busy_q   <= (state_nxt != IDLE);
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt + CNT_W'(1);
        bit_idx_nxt  = bit_idx;
        shift_nxt    = shift_q;
        data_nxt     = data_q;
        valid_nxt    = 1'b0;
        ferr_nxt     = 1'b0;

        unique case (state)
            IDLE: begin
                baud_cnt_nxt = '0;
                // fall needs a high-then-low rx_s, so a held-low line never retriggers
                if (fall) begin
                    state_nxt = START;
                end
            end

            START: begin
                if (baud_cnt == HALF_END) begin
                    baud_cnt_nxt = '0;
                    bit_idx_nxt  = '0;
                    state_nxt    = rx_s ? IDLE : DATA;
                end
            end

            DATA: begin
                if (baud_cnt == BIT_END) begin
                    shift_nxt    = {rx_s, shift_q[DATA_W-1:1]};
                    baud_cnt_nxt = '0;
                    bit_idx_nxt  = bit_idx + IDX_W'(1);
                    if (bit_idx == LAST_IDX) begin
                        state_nxt = STOP;
                    end
                end
            end

            STOP: begin
                if (baud_cnt == BIT_END) begin
                    baud_cnt_nxt = '0;
                    state_nxt    = IDLE;
                    if (rx_s) begin
                        data_nxt  = shift_q;
                        valid_nxt = 1'b1;
                    end else begin
                        ferr_nxt  = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt    = IDLE;
                baud_cnt_nxt = '0;
            end
        endcase
    end

    assign bus.data_out      = data_q;
    assign bus.data_valid    = valid_q;
    assign bus.framing_error = ferr_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at BAUD_DIVIDER=15 (16-cycle bit period).
// The line is driven on falling clk edges; outputs are observed on falling edges.
module tb_uart_receiver;

    localparam int unsigned BD = 15;
    localparam int          P  = 16;

    logic clk;
    logic rst_n;
    logic rx;

    uart_receiver_if bus ();

    assign bus.rx = rx;

    uart_receiver #(.BAUD_DIVIDER(BD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int         cyc = 0;
    logic [7:0] vq[$];
    int         vcyc = 0;
    int         ferr_cnt = 0;
    int         overlap = 0;
    int         start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor
    always @(negedge clk) begin
        if (bus.data_valid) begin
            vq.push_back(bus.data_out);
            vcyc = cyc;
        end
        if (bus.framing_error) ferr_cnt++;
        if (bus.data_valid && bus.framing_error) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start, 8 data bits LSB first, stop; each bit lasts per cycles
    task automatic send_frame(input logic [7:0] b, input logic stop, input int per);
        rx = 1'b0;
        start_cyc = cyc;
        idle(per);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(per);
        end
        rx = stop;
        idle(per);
    endtask

    // Receiver sample k (1..8) reads the pin at cycle 9+16k after the start
    // edge; bit slot j covers cycles [per*j+1, per*(j+1)] relative to it.
    function automatic logic [7:0] rx_model(input logic [7:0] b, input int per);
        logic [7:0] r;
        int         t;
        int         j;
        r = '0;
        for (int k = 1; k <= 8; k++) begin
            t = 9 + P * k;
            j = (t - 1) / per;
            if (j == 0)      r[k-1] = 1'b0;
            else if (j <= 8) r[k-1] = b[j-1];
            else             r[k-1] = 1'b1;
        end
        return r;
    endfunction

    int ferr_base;
    int lat;

    initial begin
        rx    = 1'b1;
        rst_n = 1'b0;
        idle(3);
        check("rst_data_out", 32'(bus.data_out), 32'h00);
        check("rst_valid", 32'(bus.data_valid), 32'h0);
        check("rst_ferr", 32'(bus.framing_error), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        rst_n = 1'b1;
        idle(5);

        // Single frame with latency check
        vq.delete();
        send_frame(8'hA5, 1'b1, P);
        idle(10);
        lat = vcyc - start_cyc;
        check("single_count", 32'(vq.size()), 32'd1);
        check("single_data", 32'(vq[0]), 32'hA5);
        check("single_latency", 32'((lat >= 154) && (lat <= 156)), 32'd1);
        check("single_ferr", 32'(ferr_cnt), 32'd0);

        // Back-to-back frames, no idle gap
        vq.delete();
        send_frame(8'h00, 1'b1, P);
        send_frame(8'hFF, 1'b1, P);
        send_frame(8'h3C, 1'b1, P);
        idle(20);
        check("b2b_count", 32'(vq.size()), 32'd3);
        check("b2b_0", 32'(vq[0]), 32'h00);
        check("b2b_1", 32'(vq[1]), 32'hFF);
        check("b2b_2", 32'(vq[2]), 32'h3C);

        // Glitch rejection
        vq.delete();
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(2);
        check("glitch_busy_hi", 32'(bus.busy), 32'd1);
        idle(10);
        check("glitch_busy_lo", 32'(bus.busy), 32'd0);
        check("glitch_valid", 32'(vq.size()), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt), 32'd0);

        // Framing error followed by a held-low break
        ferr_base = ferr_cnt;
        send_frame(8'h55, 1'b0, P);
        idle(40);
        check("break_busy", 32'(bus.busy), 32'd0);
        check("ferr_count", 32'(ferr_cnt - ferr_base), 32'd1);
        check("ferr_no_valid", 32'(vq.size()), 32'd0);
        check("ferr_data_held", 32'(bus.data_out), 32'h3C);
        rx = 1'b1;
        idle(20);
        check("release_busy", 32'(bus.busy), 32'd0);
        check("release_ferr", 32'(ferr_cnt - ferr_base), 32'd1);
        send_frame(8'h81, 1'b1, P);
        idle(10);
        check("after_break_count", 32'(vq.size()), 32'd1);
        check("after_break_data", 32'(vq[0]), 32'h81);

        // Transmitter bit period off by one cycle in each direction
        vq.delete();
        send_frame(8'h96, 1'b1, P - 1);
        idle(30);
        check("fast_count", 32'(vq.size()), 32'd1);
        check("fast_data", 32'(vq[0]), 32'(rx_model(8'h96, P - 1)));
        vq.delete();
        send_frame(8'h96, 1'b1, P + 1);
        idle(30);
        check("slow_count", 32'(vq.size()), 32'd1);
        check("slow_data", 32'(vq[0]), 32'h96);

        // Reset in the middle of DATA aborts the frame
        vq.delete();
        ferr_base = ferr_cnt;
        rx = 1'b0;
        idle(P);
        rx = 1'b1;
        idle(30);
        rst_n = 1'b0;
        idle(1);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_data_out", 32'(bus.data_out), 32'h00);
        rst_n = 1'b1;
        idle(200);
        check("midrst_no_valid", 32'(vq.size()), 32'd0);
        check("midrst_no_ferr", 32'(ferr_cnt - ferr_base), 32'd0);

        check("pulse_exclusive", 32'(overlap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
